// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cla, mult_seq
//  Purpose  : cla      - 4-bit carry-lookahead adder slice.
//             mult_seq - iterative shift-and-add unsigned multiplier. It forms
//                        one partial product per cycle through a chain of
//                        WIDTH/4 cla slices, and returns a 2*WIDTH-bit product
//                        through a start/done handshake.
//  Ports    : mult_seq
//               clk      in   1         rising-edge clock
//               rst      in   1         synchronous active-high reset
//               start    in   1         request, sampled while not busy
//               a        in   WIDTH     multiplicand (unsigned)
//               b        in   WIDTH     multiplier (unsigned)
//               busy     out  1         operation in progress
//               done     out  1         one-cycle completion pulse
//               product  out  2*WIDTH   last completed product
//  Revision : 1.0 - initial release
// ============================================================================

module cla (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:1] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is a flat sum of products of generate/propagate terms, so
    // no carry ripples through the slice.
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ {w_c[3:1], i_cin};
    assign o_cout = w_c[4];
endmodule

module mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic [NSLICE:0]    w_carry;
    logic [2*WIDTH-1:0] w_next;
    logic               w_last;

    // ------------------------------------------------------------------
    // Partial-product adder: acc + (q[0] ? m : 0), carry chained slice
    // to slice. The final carry becomes the top bit of the shifted pair.
    // ------------------------------------------------------------------
    assign w_addend   = r_q[0] ? r_m : '0;
    assign w_carry[0] = 1'b0;

    for (genvar k = 0; k < NSLICE; k++) begin : g_cla
        cla u_cla (
            .i_a    (r_acc[4*k +: 4]),
            .i_b    (w_addend[4*k +: 4]),
            .i_cin  (w_carry[k]),
            .o_sum  (w_sum[4*k +: 4]),
            .o_cout (w_carry[k+1])
        );
    end

    // Add-then-shift-right of the {acc, q} pair in one step.
    assign w_next = {w_carry[NSLICE], w_sum, r_q[WIDTH-1:1]};
    assign w_last = (r_cnt == C_LAST);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_m   <= a;
                        r_q   <= b;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    {r_acc, r_q} <= w_next;
                    r_cnt        <= r_cnt + 1'b1;
                    // The final iteration's result goes straight to the
                    // output register; product then holds through later runs.
                    if (w_last) begin
                        r_product <= w_next;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_seq
//  Purpose  : Self-checking bench for mult_seq (WIDTH=16). Expected products
//             come from plain multiplication; latency expectations come from
//             the start/done timing contract.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq;
    localparam int WIDTH = 16;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int total;
    int bad;

    mult_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Steps edges until done is seen (bounded). Reports edges taken and
    // whether busy stayed high (and never overlapped done) on the way.
    task automatic wait_done(output int cycles, output bit busy_ok);
        cycles  = 0;
        busy_ok = 1'b1;
        while (cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
            if (done) begin
                if (busy) busy_ok = 1'b0;
                break;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    // Issue one operation from an idle-or-done state; operands are
    // scrambled after acceptance to confirm they are only sampled once.
    task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input string name);
        int cyc;
        bit bok;
        logic [2*WIDTH-1:0] exp;
        exp   = 32'(va) * 32'(vb);
        start = 1'b1;
        a     = va;
        b     = vb;
        @(posedge clk); #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        wait_done(cyc, bok);
        check({name, "_latency"}, 64'(cyc), 64'd16);
        check({name, "_busy"}, 64'(bok), 64'd1);
        check({name, "_product"}, 64'(product), 64'(exp));
    endtask

    vec_t vecs[6];

    initial begin
        int cyc;
        bit bok;
        bit seen;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{16'd3,    16'd5,    32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h0000, 16'hFFFF, 32'h00000000};
        vecs[3] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
        vecs[4] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[5] = '{16'h1234, 16'h5678, 32'h0626_0060};

        // Reset then idle
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            start = 1'b1;
            a     = vecs[i].a;
            b     = vecs[i].b;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done(cyc, bok);
            check($sformatf("vec%0d_latency", i), 64'(cyc), 64'd16);
            check($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
            check($sformatf("vec%0d_product", i), 64'(product), 64'(vecs[i].exp));
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_one_cycle", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_idle", i), 64'(busy), 64'd0);
            check($sformatf("vec%0d_hold", i), 64'(product), 64'(vecs[i].exp));
        end

        // Start held high through RUN with changing operands: ignored.
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h0000;
        @(posedge clk); #1;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 60 && !seen) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom) | 16'h0001;
            @(posedge clk); #1;
            cyc++;
            seen = done;
        end
        check("ignore_latency", 64'(cyc), 64'd16);
        check("ignore_product", 64'(product), 64'd0);
        // Back-to-back: start during DONE
        a = 16'h00FF;
        b = 16'h0100;
        wait_done(cyc, bok);
        start = 1'b0;
        check("b2b_latency", 64'(cyc), 64'd17);
        check("b2b_busy", 64'(bok), 64'd1);
        check("b2b_product", 64'(product), 64'h0000FF00);
        @(posedge clk); #1;

        // Reset mid-run
        start = 1'b1;
        a     = 16'd7;
        b     = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("midrun_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_busy", 64'(busy), 64'd0);
        check("midrun_done", 64'(done), 64'd0);
        check("midrun_product", 64'(product), 64'd0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("midrun_quiet", 64'(seen), 64'd0);
        run_op(16'd7, 16'd9, "after_rst");
        check("after_rst_value", 64'(product), 64'h3F);

        // Random operations with random gaps
        for (int n = 0; n < 1000; n++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if (n % 50 == 0) ra = 16'hFFFF;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_op(ra, rb, $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
